// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer (CTRL/PRESET/COUNT) driving one CP0 HWInt line.
// Define TIMER_AUTO_RELOAD_EN to implement auto-reload mode (Mode = 01); otherwise every mode is one-shot.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CTRL_W-1:0]   ctrl, ctrl_nxt;
  logic [DATA_W-1:0]   preset, preset_nxt;
  logic [DATA_W-1:0]   count, count_nxt;
  logic                irq_flag, irq_flag_nxt;

  logic enable;
  logic irq_mask;
  logic reload;
  logic wr_ctrl;
  logic wr_preset;

  assign enable    = ctrl[0];
  assign irq_mask  = ctrl[3];
  assign wr_ctrl   = WE && (Addr == ADDR_CTRL);
  assign wr_preset = WE && (Addr == ADDR_PRESET);

`ifdef TIMER_AUTO_RELOAD_EN
  assign reload = (ctrl[2:1] == 2'b01);
`else
  assign reload = 1'b0;
`endif

  // State and programmer-visible registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      ctrl     <= ctrl_nxt;
      preset   <= preset_nxt;
      count    <= count_nxt;
      irq_flag <= irq_flag_nxt;
    end
  end

  // Next-state and datapath; software writes are applied last so they win
  always_comb begin
    state_nxt    = state;
    ctrl_nxt     = ctrl;
    preset_nxt   = preset;
    count_nxt    = count;
    irq_flag_nxt = irq_flag;

    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (count > DATA_W'(1)) begin
          count_nxt = count - DATA_W'(1);
        end else begin
          count_nxt    = '0;
          irq_flag_nxt = 1'b1;
          state_nxt    = ST_INT;
        end
      end
      ST_INT: begin
        if (reload) begin
          irq_flag_nxt = 1'b0;
          state_nxt    = ST_LOAD;
        end else begin
          ctrl_nxt[0] = 1'b0;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (wr_ctrl) begin
      ctrl_nxt     = CTRL_W'(Din);
      irq_flag_nxt = 1'b0;
    end
    if (wr_preset) begin
      preset_nxt   = Din;
      irq_flag_nxt = 1'b0;
    end
  end

  // Combinational read port
  always_comb begin
    Dout = '0;
    case (Addr)
      ADDR_CTRL:   Dout = DATA_W'(ctrl);
      ADDR_PRESET: Dout = preset;
      ADDR_COUNT:  Dout = count;
      default:     Dout = '0;
    endcase
  end

  assign IRQ = irq_flag & irq_mask;

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed timing checks plus randomized register traffic against a reference model.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int failures = 0;

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (addr),
    .WE    (we),
    .Din   (din),
    .Dout  (dout),
    .IRQ   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic irqc(input string tag, input logic exp);
    #1;
    check(tag, 32'(irq), 32'(exp));
  endtask

  task automatic do_reset();
    we    = 1'b0;
    addr  = 2'd0;
    din   = 32'd0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  // Reference model: timer registers plus the phase of the countdown sequence
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_EXP = 3;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  logic        m_flag;
  int          m_ph;

  task automatic m_reset();
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_ph = PH_IDLE;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step(input logic w, input logic [1:0] a, input logic [31:0] d);
    logic [3:0]  n_ctrl;
    logic [31:0] n_pre, n_cnt;
    logic        n_flag, auto;
    int          n_ph;
    n_ctrl = m_ctrl; n_pre = m_preset; n_cnt = m_count; n_flag = m_flag; n_ph = m_ph;
`ifdef TIMER_AUTO_RELOAD_EN
    auto = (m_ctrl[2:1] == 2'b01);
`else
    auto = 1'b0;
`endif
    if (m_ph == PH_IDLE) begin
      if (m_ctrl[0]) n_ph = PH_LOAD;
    end else if (m_ph == PH_LOAD) begin
      n_cnt = m_preset; n_ph = PH_RUN;
    end else if (m_ph == PH_RUN) begin
      if (!m_ctrl[0]) n_ph = PH_IDLE;
      else if (m_count > 32'd1) n_cnt = m_count - 32'd1;
      else begin n_cnt = 32'd0; n_flag = 1'b1; n_ph = PH_EXP; end
    end else begin
      if (auto) begin n_flag = 1'b0; n_ph = PH_LOAD; end
      else begin n_ctrl[0] = 1'b0; n_ph = PH_IDLE; end
    end
    if (w && a == 2'd0) begin n_ctrl = d[3:0]; n_flag = 1'b0; end
    if (w && a == 2'd1) begin n_pre = d; n_flag = 1'b0; end
    m_ctrl = n_ctrl; m_preset = n_pre; m_count = n_cnt; m_flag = n_flag; m_ph = n_ph;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic        exp_irq;

    // Reset state
    do_reset();
    rd("rst_ctrl", 2'd0, 32'd0);
    rd("rst_preset", 2'd1, 32'd0);
    rd("rst_count", 2'd2, 32'd0);
    rd("rst_resv", 2'd3, 32'd0);
    irqc("rst_irq", 1'b0);

    // One-shot, N = 5
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step();
    step(); rd("os_count_e2", 2'd2, 32'd5);
    repeat (4) step(); irqc("os_irq_e6", 1'b0);
    step(); irqc("os_irq_e7", 1'b1); rd("os_ctrl_e7", 2'd0, 32'h9);
    step(); rd("os_ctrl_e8", 2'd0, 32'h8); irqc("os_irq_e8", 1'b1);
    repeat (3) step(); irqc("os_irq_hold", 1'b1);
    wr(2'd0, 32'h8); irqc("os_irq_clr", 1'b0);

    // PRESET = 0 expires at E+3
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    repeat (2) step(); irqc("n0_irq_e2", 1'b0);
    step(); irqc("n0_irq_e3", 1'b1);

    // Pause at COUNT = 2, ignored writes, restart from PRESET
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    repeat (9) step(); rd("pause_cnt3", 2'd2, 32'd3);
    wr(2'd0, 32'h8); rd("pause_cnt2", 2'd2, 32'd2);
    repeat (3) step(); rd("pause_frozen", 2'd2, 32'd2); irqc("pause_irq", 1'b0);
    wr(2'd2, 32'h0000_FFFF); rd("cnt_wr_ign", 2'd2, 32'd2);
    wr(2'd3, 32'hFFFF_FFFF); rd("resv_rd", 2'd3, 32'd0); rd("resv_wr_ign", 2'd1, 32'd10);
    wr(2'd0, 32'h9);
    repeat (2) step(); rd("pause_reload", 2'd2, 32'd10);

    // Masked expiry; writing CTRL afterwards clears the pending flag
    do_reset();
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    repeat (6) step(); irqc("mask_irq", 1'b0);
    step(); rd("mask_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h9); irqc("mask_after_im", 1'b0);
    repeat (5) step(); irqc("mask_rerun_e6", 1'b0);
    step(); irqc("mask_rerun_e7", 1'b1);

    // CTRL write in the INT cycle: software value wins, restart via IDLE -> LOAD
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    repeat (4) step(); irqc("int_irq", 1'b1);
    wr(2'd0, 32'h9); rd("int_ctrl", 2'd0, 32'h9); irqc("int_irq_clr", 1'b0);
    repeat (2) step(); rd("int_reload", 2'd2, 32'd2);
    step(); irqc("int_rerun_e3", 1'b0);
    step(); irqc("int_rerun_e4", 1'b1);

    // Asynchronous reset mid-count
    do_reset();
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    repeat (52) step(); rd("mid_cnt50", 2'd2, 32'd50);
    reset = 1'b1;
    irqc("mid_rst_irq", 1'b0);
    rd("mid_rst_ctrl", 2'd0, 32'd0);
    rd("mid_rst_preset", 2'd1, 32'd0);
    rd("mid_rst_count", 2'd2, 32'd0);
    rd("mid_rst_resv", 2'd3, 32'd0);
    reset = 1'b0;
    repeat (3) step(); rd("mid_idle_cnt", 2'd2, 32'd0);

    // Auto-reload stimulus: periodic pulses with the feature, one latched IRQ without
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 22; k++) begin
      step();
`ifdef TIMER_AUTO_RELOAD_EN
      exp_irq = (k >= 5) && ((k - 5) % 5 == 0);
`else
      exp_irq = (k >= 5);
`endif
      irqc("ar_irq", exp_irq);
    end
`ifdef TIMER_AUTO_RELOAD_EN
    rd("ar_ctrl", 2'd0, 32'hB);
`else
    rd("ar_ctrl", 2'd0, 32'hA);
`endif

    // Randomized traffic against the reference model
    do_reset();
    m_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 99) == 0) begin
        we    = 1'b0;
        reset = 1'b1;
        addr  = 2'($urandom);
        #1;
        m_reset();
        check("rnd_rst_dout", dout, 32'd0);
        check("rnd_rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
      end else begin
        we   = ($urandom_range(0, 9) == 0);
        addr = 2'($urandom);
        v    = $urandom;
        if (addr == 2'd0 && $urandom_range(0, 3) != 0) v[0] = 1'b1;
        if (addr == 2'd1 && $urandom_range(0, 19) != 0) v = 32'($urandom_range(0, 8));
        din = v;
      end
      #1;
      check("rnd_dout", dout, m_read(addr));
      check("rnd_irq", 32'(irq), 32'(m_flag & m_ctrl[3]));
      @(posedge clk);
      m_step(we, addr, din);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
